mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch path (port 0) and the load/store path (port 1).
- Replaces the hard-wired pc/result address mux in front of the memory with a valid/ready front end, a starvation-bounded priority arbiter and a response-routing pipeline.
- Sits between the core's fetch/LSU logic and the memory model; at most one memory access issues per cycle.

Parameters:
- AW, 32, address width passed to memory.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).
- STARVE_MAX, 4, maximum consecutive data grants while fetch waits before fetch is forced (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- hold  in  1  when 1, no new grant issues; in-flight responses still drain.
- if_valid  in  1  fetch request valid.
- if_ready  out  1  fetch request accepted this cycle.
- if_addr  in  AW  fetch address.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- d_valid  in  1  data request valid.
- d_ready  out  1  data request accepted this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DW  load data.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the address is issued.
- busy  out  1  any response in flight.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Clears the starvation counter and the in-flight shift register.
  - While rst_n=0: if_ready, d_ready, mem_we, if_rvalid, d_rvalid and busy are all 0, and mem_addr = 0.
  - Responses in flight when reset is applied are dropped and never delivered.
- Handshake:
  - A request transfers in the cycle where valid & ready = 1.
  - The requester holds addr, we and wdata stable while valid=1 and ready=0.
  - ready is combinational from valid, hold and arbiter state; it never asserts without valid.
- Grant (combinational, same cycle):
  - If hold=1, no grant.
  - If only one port is valid, that port is granted.
  - If both are valid, the data port wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - The granted port drives mem_addr. mem_we = d_we & data granted; mem_wdata = d_wdata. With no grant, mem_we = 0.
- Starvation counter (4 bits, registered):
  - Increments when data is granted while if_valid=1.
  - Clears when fetch is granted or if_valid=0.
  - Saturates at STARVE_MAX.
- Response routing:
  - A MEM_LAT-deep shift register of {valid, port} entries.
  - A granted read (fetch, or data with d_we=0) enters stage 0 as {1, port}; stores and idle cycles enter {0, x}.
  - When the last stage holds valid: the matching *_rvalid pulses for exactly one cycle, with *_rdata = mem_rdata. The other port's rvalid stays 0.
  - Responses return in issue order with latency exactly MEM_LAT cycles after the accept cycle.
- Stores generate no response; acceptance is completion. A load issued in the cycle after a store to the same address returns the new data; this relies on memory write-before-read ordering.
- busy = OR of the shift-register valid bits.
- *_rdata when *_rvalid=0: drives mem_rdata, and consumers ignore it.
- hold asserted mid-stream: issue stops the same cycle, and already-issued reads still complete on schedule.
- Throughput: one request per cycle back-to-back on either port.

Test Plan:
- Reset: rst_n=0 for 2 cycles with if_valid=d_valid=1 -> if_ready=d_ready=mem_we=0. Release -> d_ready=1 on the first cycle.
- Fetch only: if_addr=0x10, memory word 0x00500093 -> if_ready=1 at cycle t, if_rvalid=1 with if_rdata=0x00500093 at t+MEM_LAT, d_rvalid=0 throughout.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, then d_we=0, d_addr=0x40 next cycle -> mem_we=1 for one cycle only, d_rvalid one cycle later with d_rdata=0xDEADBEEF, no response for the store.
- Starvation: if_valid and d_valid held at 1 for 12 cycles, STARVE_MAX=4 -> grant pattern D,D,D,D,F repeating; if_ready asserts on cycles 5 and 10.
- Hold: hold=1 on the cycle after a fetch read is accepted, MEM_LAT=2 -> no new ready while hold=1; the pending if_rvalid still appears 2 cycles after its accept; busy drops to 0 afterwards.
- Reset mid-flight: load accepted at t, rst_n=0 at t+1 -> no d_rvalid ever delivered; busy=0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port front end for the single-port unified memory: fetch (port 0) and load/store (port 1)
// share one access slot per cycle under a starvation-bounded priority, with in-order response routing.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,

    input  logic          if_valid,
    output logic          if_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_valid,
    output logic          d_ready,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam int         LAST       = MEM_LAT - 1;

    logic [3:0] r_starve;

    logic w_issue_ok;
    logic w_fetch_forced;
    logic w_gnt_f;
    logic w_gnt_d;
    logic w_rsp_vld;

    // Data normally wins; fetch is forced once data has been granted STARVE_MAX times in a row over it.
    assign w_issue_ok     = rst_n & ~hold;
    assign w_fetch_forced = (r_starve == STARVE_LIM);
    assign w_gnt_d        = w_issue_ok & d_valid & (~if_valid | ~w_fetch_forced);
    assign w_gnt_f        = w_issue_ok & if_valid & ~w_gnt_d;

    assign if_ready  = w_gnt_f;
    assign d_ready   = w_gnt_d;
    assign mem_addr  = w_gnt_f ? if_addr : (w_gnt_d ? d_addr : '0);
    assign mem_we    = w_gnt_d & d_we;
    assign mem_wdata = d_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (w_gnt_f || !if_valid) begin
            r_starve <= 4'd0;
        end else if (w_gnt_d && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Stores complete on acceptance, so only reads occupy a slot in the return pipeline.
    assign w_rsp_vld = w_gnt_f | (w_gnt_d & ~d_we);

    logic         r_vld  [MEM_LAT];
    logic         r_port [MEM_LAT];
    logic [MEM_LAT:0] w_any_vld;

    assign w_any_vld[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_vld[gi]  <= 1'b0;
                        r_port[gi] <= 1'b0;
                    end else begin
                        r_vld[gi]  <= w_rsp_vld;
                        r_port[gi] <= w_gnt_d;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_vld[gi]  <= 1'b0;
                        r_port[gi] <= 1'b0;
                    end else begin
                        r_vld[gi]  <= r_vld[gi-1];
                        r_port[gi] <= r_port[gi-1];
                    end
                end
            end
            assign w_any_vld[gi+1] = w_any_vld[gi] | r_vld[gi];
        end
    endgenerate

    assign if_rvalid = rst_n & r_vld[LAST] & ~r_port[LAST];
    assign d_rvalid  = rst_n & r_vld[LAST] & r_port[LAST];
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = rst_n & w_any_vld[MEM_LAT];

endmodule
